// File: rtl/mux_pkg.sv
// Shared definitions for the mux select controllers: channel count, select
// width, FSM state type and the rotate-priority arbitration function.
package mux_pkg;

  localparam int NCH = 4;
  localparam int SW  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate-priority search: first requesting channel starting at ptr,
  // wrapping 3 -> 0. Result is {found, idx}; idx is 0 when nothing is found.
  function automatic logic [SW:0] arb(input logic [NCH-1:0] req,
                                      input logic [SW-1:0]  ptr);
    logic [SW:0]   res;
    logic [SW-1:0] idx;
    res = '0;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr + SW'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// 4-input rotate-priority encoder: picks the first active request at or
// after ptr (wrapping), purely combinational.
module rr_prio_enc
  import mux_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic [SW-1:0]  idx,
  output logic           found
);

  // Single search evaluated on the supplied pointer.
  always_comb begin
    {found, idx} = arb(req, ptr);
  end

endmodule

// File: rtl/mux4x1_rr_sel.sv
// Round-robin select generator for the 4:1 mux. Holds a grant for BEATS
// accepted transfers (or until the owner withdraws) and then rotates.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant; looking for a requester starting at ptr
//   GRANT | s owns the mux; counting accepted beats in cnt
module mux4x1_rr_sel
  import mux_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic            out_ready,
  output logic [SW-1:0]   s,
  output logic            sel_valid,
  output logic [NCH-1:0]  grant,
  output logic            sel_last
);

  localparam int            CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);

  state_t        state;
  logic [SW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic          beat;
  logic          withdraw;
  logic          rel_now;
  logic [SW-1:0] enc_ptr;
  logic [SW-1:0] enc_idx;
  logic          enc_found;

  assign beat     = sel_valid & out_ready;
  assign withdraw = (state == GRANT) & ~req[s];
  assign rel_now  = (state == GRANT) & (withdraw | (beat & (cnt == CNT_LAST)));

  // On release the search must already start past the outgoing owner so the
  // next grant can follow without an idle bubble.
  assign enc_ptr = (state == GRANT) ? (s + SW'(1)) : ptr;

  rr_prio_enc u_enc (
    .req   (req),
    .ptr   (enc_ptr),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // Grant FSM with beat counter and rotation pointer; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      sel_valid <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_found) begin
            state     <= GRANT;
            s         <= enc_idx;
            sel_valid <= 1'b1;
            cnt       <= '0;
          end
        end
        GRANT: begin
          if (rel_now) begin
            ptr <= enc_ptr;
            cnt <= '0;
            if (enc_found) begin
              s <= enc_idx;
            end else begin
              state     <= IDLE;
              sel_valid <= 1'b0;
            end
          end else if (beat) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          sel_valid <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

  // One-hot view of the select, forced to zero when no grant is held.
  always_comb begin
    grant = '0;
    if (sel_valid) grant[s] = 1'b1;
  end

  assign sel_last = sel_valid & (cnt == CNT_LAST);

endmodule

// File: tb/tb_mux4x1_rr_sel.sv
// Self-checking bench for mux4x1_rr_sel: a grant-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mux4x1_rr_sel;

  localparam int BEATS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       out_ready = 1'b0;

  logic [1:0] s;
  logic       sel_valid;
  logic [3:0] grant;
  logic       sel_last;

  int n_cmp = 0;
  int n_bad = 0;

  mux4x1_rr_sel #(.BEATS(BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .s         (s),
    .sel_valid (sel_valid),
    .grant     (grant),
    .sel_last  (sel_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the grant and how many beats it has taken.
  bit m_act  = 1'b0;
  int m_ch   = 0;
  int m_ptr  = 0;
  int m_done = 0;

  function automatic int search(input logic [3:0] r, input int from);
    for (int k = 0; k < 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int k;
    int np;
    bit rel;
    if (rst) begin
      m_act  <= 1'b0;
      m_ch   <= 0;
      m_ptr  <= 0;
      m_done <= 0;
    end else if (!m_act) begin
      k = search(req, m_ptr);
      if (k >= 0) begin
        m_act  <= 1'b1;
        m_ch   <= k;
        m_done <= 0;
      end
    end else begin
      rel = !req[m_ch] || (out_ready && (m_done == BEATS - 1));
      if (rel) begin
        np = (m_ch + 1) % 4;
        m_ptr <= np;
        k = search(req, np);
        if (k >= 0) begin
          m_ch   <= k;
          m_done <= 0;
        end else begin
          m_act <= 1'b0;
        end
      end else if (out_ready) begin
        m_done <= m_done + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("sel_valid", int'(sel_valid), int'(m_act));
    check("grant", int'(grant), m_act ? (1 << m_ch) : 0);
    check("sel_last", int'(sel_last), int'(m_act && (m_done == BEATS - 1)));
    if (m_act) check("s", int'(s), m_ch);
    if (rst) check("s_in_reset", int'(s), 0);
  end

  // One stimulus cycle: drive just after the edge, return at the falling edge.
  task automatic cyc(input logic [3:0] r, input logic rdy);
    @(posedge clk);
    #1;
    req = r;
    out_ready = rdy;
    @(negedge clk);
  endtask

  // Mid-cycle reset pulse; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = 4'b0000;
    out_ready = 1'b0;
    #1;
    check({tag, "_async_valid"}, int'(sel_valid), 0);
    check({tag, "_async_grant"}, int'(grant), 0);
    check({tag, "_async_s"}, int'(s), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int lasts;
    int drops;
    int rot_exp [5];
    rot_exp = '{0, 1, 2, 3, 0};

    // Reset and idle
    @(negedge clk);
    #1;
    rst = 1'b0;
    do_reset("rst0");
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0000, 1'b0);
      check("idle_valid", int'(sel_valid), 0);
    end

    // Single channel: lone requester re-granted every BEATS beats
    cyc(4'b0100, 1'b1);
    check("single_latency", int'(sel_valid), 0);
    lasts = 0;
    drops = 0;
    for (int j = 1; j <= 12; j++) begin
      cyc(4'b0100, 1'b1);
      if (j == 1) begin
        check("single_s", int'(s), 2);
        check("single_grant", int'(grant), 4);
      end
      if (sel_last) lasts++;
      if (!sel_valid) drops++;
    end
    check("single_last_pulses", lasts, 3);
    check("single_valid_drops", drops, 0);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);

    // Full rotation from ptr=0
    do_reset("rst1");
    cyc(4'b1111, 1'b1);
    drops = 0;
    for (int j = 1; j <= 20; j++) begin
      cyc(4'b1111, 1'b1);
      if (!sel_valid) drops++;
      if ((j - 1) % 4 == 0) check("rot_s", int'(s), rot_exp[(j - 1) / 4]);
    end
    check("rot_bubbles", drops, 0);

    // Backpressure: ready pattern 1,0,0,1 per cycle
    do_reset("rst2");
    for (int j = 0; j <= 9; j++) begin
      cyc(4'b0011, ((j % 4) == 0) || ((j % 4) == 3));
      if (j == 6) check("bp_hold_s", int'(s), 0);
      if (j == 8) begin
        check("bp_last_s", int'(s), 0);
        check("bp_last", int'(sel_last), 1);
      end
      if (j == 9) begin
        check("bp_next_s", int'(s), 1);
        check("bp_next_valid", int'(sel_valid), 1);
      end
    end

    // Withdrawal on channel 3 with wrap-around search finding channel 1
    do_reset("rst3");
    cyc(4'b1000, 1'b1);
    cyc(4'b1000, 1'b1);
    check("wd_s3", int'(s), 3);
    cyc(4'b0010, 1'b1);
    check("wd_hold_s3", int'(s), 3);
    cyc(4'b0010, 1'b1);
    check("wd_wrap_s", int'(s), 1);
    check("wd_wrap_grant", int'(grant), 2);
    check("wd_wrap_last", int'(sel_last), 0);

    // Reset in the middle of a grant (s=2, cnt=2)
    do_reset("rst4");
    for (int j = 0; j <= 3; j++) cyc(4'b0100, 1'b1);
    check("mid_s", int'(s), 2);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(sel_valid), 0);
    check("mid_rst_grant", int'(grant), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc(4'b0100, 1'b1);
      check("restart_valid", int'(sel_valid), 1);
      check("restart_last", int'(sel_last), int'(k == 4));
    end
    cyc(4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
